// File: rtl/pagerank_mem_arbiter.sv
// Round-robin arbiter sharing one in-order memory port among NREQS requesters.
// Optional per-requester grant counters are enabled with PAGERANK_MEM_ARB_STATS_EN.
module pagerank_mem_arbiter #(
    parameter int NREQS = 2,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQS*77-1:0]   req_msg,
    input  logic [NREQS-1:0]      req_val,
    output logic [NREQS-1:0]      req_rdy,
    output logic [NREQS*47-1:0]   resp_msg,
    output logic [NREQS-1:0]      resp_val,
    input  logic [NREQS-1:0]      resp_rdy,
    output logic [76:0]           mem_req_msg,
    output logic                  mem_req_val,
    input  logic                  mem_req_rdy,
    input  logic [46:0]           mem_resp_msg,
    input  logic                  mem_resp_val,
    output logic                  mem_resp_rdy
`ifdef PAGERANK_MEM_ARB_STATS_EN
    ,
    output logic [NREQS*16-1:0]   grant_count
`endif
);

    // Handshake rule on every port: a transfer happens in a cycle where valid
    // and ready are both high; ready never waits on a later cycle's valid.

    localparam int IW = $clog2(NREQS);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [IW-1:0] LAST_ID  = IW'(NREQS - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [IW-1:0] prio_ptr;
    logic [IW-1:0] winner;
    logic [IW-1:0] idx;
    logic [IW-1:0] tag;
    logic          any_val;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [IW-1:0] tags [DEPTH];

    logic [76:0]   req_slice [NREQS];

    for (genvar g = 0; g < NREQS; g++) begin : g_port
        assign req_slice[g]          = req_msg[g*77 +: 77];
        assign resp_msg[g*47 +: 47]  = mem_resp_msg;
    end

    // First valid requester at or after prio_ptr, wrapping modulo NREQS.
    always_comb begin
        winner  = '0;
        any_val = 1'b0;
        idx     = '0;
        for (int k = 0; k < NREQS; k++) begin
            idx = IW'((int'(prio_ptr) + k) % NREQS);
            if (!any_val && req_val[idx]) begin
                winner  = idx;
                any_val = 1'b1;
            end
        end
    end

    assign fifo_full   = (count == FULL_CNT);
    assign fifo_empty  = (count == '0);
    assign mem_req_val = any_val && !fifo_full;
    assign mem_req_msg = req_slice[winner];
    assign push        = mem_req_val && mem_req_rdy;

    always_comb begin
        req_rdy         = '0;
        req_rdy[winner] = any_val && mem_req_rdy && !fifo_full;
    end

    assign tag          = tags[head];
    assign mem_resp_rdy = !fifo_empty && resp_rdy[tag];
    assign pop          = mem_resp_val && mem_resp_rdy;

    always_comb begin
        resp_val      = '0;
        resp_val[tag] = mem_resp_val && !fifo_empty;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_ptr <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                tail     <= tail + PW'(1);
                prio_ptr <= (winner == LAST_ID) ? '0 : winner + IW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Tag storage needs no reset: entries are only read while count marks them live.
    always_ff @(posedge clk) begin
        if (push) begin
            tags[tail] <= winner;
        end
    end

`ifdef PAGERANK_MEM_ARB_STATS_EN
    logic [15:0] gcnt [NREQS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREQS; i++) begin
                gcnt[i] <= '0;
            end
        end else if (push && gcnt[winner] != 16'hFFFF) begin
            gcnt[winner] <= gcnt[winner] + 16'd1;
        end
    end

    for (genvar g = 0; g < NREQS; g++) begin : g_stat
        assign grant_count[g*16 +: 16] = gcnt[g];
    end
`endif

endmodule

// File: tb/tb_pagerank_mem_arbiter.sv
// Scoreboard bench for pagerank_mem_arbiter: directed scenarios plus randomized traffic
// against a queue-based reference model; define PAGERANK_MEM_ARB_STATS_EN to exercise counters.
module tb_pagerank_mem_arbiter;
    localparam int NREQS = 2;
    localparam int DEPTH = 4;
    localparam int EW    = 49;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQS*77-1:0] req_msg;
    logic [NREQS-1:0]    req_val;
    logic [NREQS-1:0]    req_rdy;
    logic [NREQS*47-1:0] resp_msg;
    logic [NREQS-1:0]    resp_val;
    logic [NREQS-1:0]    resp_rdy;
    logic [76:0]         mem_req_msg;
    logic                mem_req_val;
    logic                mem_req_rdy;
    logic [46:0]         mem_resp_msg;
    logic                mem_resp_val;
    logic                mem_resp_rdy;
`ifdef PAGERANK_MEM_ARB_STATS_EN
    logic [NREQS*16-1:0] grant_count;
`endif

    pagerank_mem_arbiter #(.NREQS(NREQS), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_msg      (req_msg),
        .req_val      (req_val),
        .req_rdy      (req_rdy),
        .resp_msg     (resp_msg),
        .resp_val     (resp_val),
        .resp_rdy     (resp_rdy),
        .mem_req_msg  (mem_req_msg),
        .mem_req_val  (mem_req_val),
        .mem_req_rdy  (mem_req_rdy),
        .mem_resp_msg (mem_resp_msg),
        .mem_resp_val (mem_resp_val),
        .mem_resp_rdy (mem_resp_rdy)
`ifdef PAGERANK_MEM_ARB_STATS_EN
        ,
        .grant_count  (grant_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: outstanding requester IDs in issue order, and the rotating priority.
    int          tags_q[$];
    int          prio;
    int          cnt_model[NREQS];
    logic [EW-1:0] exp_q[$];
    logic [46:0] mem_pend[$];
    logic [7:0]  grant_log[$];
    logic        hold_val[NREQS];
    logic [76:0] hold_msg[NREQS];
    int          p_req[NREQS];
    int          p_mrdy, p_mval, p_rrdy;
    bit          stray, tag_opq;
    int          dut_fires, resp_fires;
    logic [NREQS-1:0] last_rv;
    logic [46:0]      last_msg;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [46:0] mem_fn(input logic [76:0] r);
        return {r[76:74], r[73:66], r[35:34], r[33:32], r[31:0] ^ r[65:34]};
    endfunction

    function automatic int rr_pick(input logic [NREQS-1:0] v, input int p);
        for (int k = 0; k < NREQS; k++) begin
            if (v[(p + k) % NREQS]) return (p + k) % NREQS;
        end
        return -1;
    endfunction

    task automatic clear_model();
        tags_q.delete();
        exp_q.delete();
        mem_pend.delete();
        grant_log.delete();
        prio = 0;
        for (int i = 0; i < NREQS; i++) begin
            cnt_model[i] = 0;
            hold_val[i]  = 1'b0;
        end
    endtask

    task automatic do_cycle();
        logic [95:0]      rnd;
        logic [NREQS-1:0] exp_rr, exp_rv;
        int               w, head;
        bit               full, exp_mreq_val, exp_mrr;
        @(negedge clk);
        for (int i = 0; i < NREQS; i++) begin
            if (!hold_val[i] && $urandom_range(0, 99) < p_req[i]) begin
                rnd = {$urandom, $urandom, $urandom};
                hold_val[i] = 1'b1;
                hold_msg[i] = rnd[76:0];
                if (tag_opq) hold_msg[i][73:66] = 8'(i);
            end
            req_val[i]            = hold_val[i];
            req_msg[i*77 +: 77]   = hold_msg[i];
            resp_rdy[i]           = ($urandom_range(0, 99) < p_rrdy);
        end
        mem_req_rdy = ($urandom_range(0, 99) < p_mrdy);
        if (mem_pend.size() > 0) begin
            mem_resp_val = ($urandom_range(0, 99) < p_mval);
            mem_resp_msg = mem_pend[0];
        end else begin
            rnd          = {$urandom, $urandom, $urandom};
            mem_resp_val = stray;
            mem_resp_msg = rnd[46:0];
        end
        #2;
        w            = rr_pick(req_val, prio);
        full         = (tags_q.size() >= DEPTH);
        exp_mreq_val = (w >= 0) && !full;
        exp_rr       = '0;
        if (w >= 0 && mem_req_rdy && !full) exp_rr[w] = 1'b1;
        chk("mem_req_val", mem_req_val, exp_mreq_val);
        chk("req_rdy", req_rdy, exp_rr);
        if (exp_mreq_val) chk("mem_req_msg", mem_req_msg, hold_msg[w]);
        head   = (tags_q.size() > 0) ? tags_q[0] : -1;
        exp_rv = '0;
        if (head >= 0 && mem_resp_val) exp_rv[head] = 1'b1;
        exp_mrr = (head >= 0) && resp_rdy[head];
        chk("resp_val", resp_val, exp_rv);
        chk("mem_resp_rdy", mem_resp_rdy, exp_mrr);
        for (int i = 0; i < NREQS; i++) chk("resp_msg_bcast", resp_msg[i*47 +: 47], mem_resp_msg);
        // Memory emulator reacts to what the DUT actually presents.
        if (mem_req_val && mem_req_rdy) begin
            mem_pend.push_back(mem_fn(mem_req_msg));
            grant_log.push_back(mem_req_msg[73:66]);
            dut_fires++;
        end
        if (mem_resp_val && mem_resp_rdy && mem_pend.size() > 0) void'(mem_pend.pop_front());
        if (head >= 0 && mem_resp_val && resp_rdy[head]) void'(tags_q.pop_front());
        if (exp_mreq_val && mem_req_rdy) begin
            tags_q.push_back(w);
            exp_q.push_back({2'(w), mem_fn(hold_msg[w])});
            hold_val[w] = 1'b0;
            prio = (w + 1) % NREQS;
            cnt_model[w]++;
        end
    endtask

    task automatic set_knobs(input int pr, input int mrdy, input int mval, input int rrdy);
        for (int i = 0; i < NREQS; i++) p_req[i] = pr;
        p_mrdy = mrdy;
        p_mval = mval;
        p_rrdy = rrdy;
    endtask

    task automatic drain();
        int n = 0;
        set_knobs(0, 100, 100, 100);
        stray = 1'b0;
        while ((tags_q.size() > 0 || mem_pend.size() > 0 || hold_val[0] || hold_val[1]) && n < 300) begin
            do_cycle();
            n++;
        end
        if (n >= 300) chk("drain_timeout", 1, 0);
        #3;
    endtask

    task automatic do_reset(input bit stray_in);
        @(negedge clk);
        req_val      = '0;
        mem_resp_val = stray_in;
        mem_req_rdy  = 1'b1;
        resp_rdy     = '1;
        #1 reset = 1'b1;
        #1;
        chk("rst_resp_val", resp_val, '0);
        chk("rst_mem_resp_rdy", mem_resp_rdy, 1'b0);
        chk("rst_req_rdy", req_rdy, '0);
        chk("rst_mem_req_val", mem_req_val, 1'b0);
        clear_model();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: pops the expected queue on every accepted memory response.
    initial begin
        logic [EW-1:0]    e;
        logic [NREQS-1:0] erv;
        int               p;
        forever begin
            @(negedge clk);
            #4;
            if (!reset && mem_resp_val && mem_resp_rdy) begin
                resp_fires++;
                last_rv  = resp_val;
                last_msg = resp_msg[47 +: 47];
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", mem_resp_rdy, 1'b0);
                end else begin
                    e      = exp_q.pop_front();
                    p      = int'(e[48:47]);
                    erv    = '0;
                    erv[p] = 1'b1;
                    chk("sb_resp_port", resp_val, erv);
                    chk("sb_resp_msg", resp_msg[p*47 +: 47], e[46:0]);
                end
            end
        end
    end

    initial begin
        int f0;
        reset = 1'b1;
        req_val = '0;
        req_msg = '0;
        resp_rdy = '0;
        mem_req_rdy = 1'b0;
        mem_resp_val = 1'b1;
        mem_resp_msg = '0;
        stray = 1'b0;
        tag_opq = 1'b0;
        dut_fires = 0;
        resp_fires = 0;
        clear_model();
        set_knobs(0, 100, 100, 100);
        @(negedge clk);
        resp_rdy = '1;
        #1;
        chk("reset_resp_val", resp_val, '0);
        chk("reset_mem_resp_rdy", mem_resp_rdy, 1'b0);
        chk("reset_mem_req_val", mem_req_val, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Single requester on port 1.
        hold_val[1] = 1'b1;
        hold_msg[1] = {3'd0, 8'h5A, 32'h0000_0100, 2'd0, 32'hDEADBFEF};
        for (int c = 0; c < 6; c++) do_cycle();
        #3;
        chk("single_resp_val", last_rv, 2'b10);
        chk("single_data", last_msg[31:0], 32'hDEADBEEF);
        chk("single_opaque", last_msg[43:36], 8'h5A);
        drain();

        // Contention: both ports always requesting.
        grant_log.delete();
        tag_opq = 1'b1;
        set_knobs(100, 100, 100, 100);
        for (int c = 0; c < 4; c++) do_cycle();
        tag_opq = 1'b0;
        chk("cont_nfires", grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("cont_grant", grant_log[i], 8'(i % 2));
        drain();

        // FIFO full with responses withheld.
        dut_fires = 0;
        set_knobs(100, 100, 0, 100);
        for (int c = 0; c < 8; c++) do_cycle();
        chk("full_fires", dut_fires, 4);
        chk("full_mem_req_val", mem_req_val, 1'b0);
        chk("full_req_rdy", req_rdy, '0);
        dut_fires = 0;
        p_mval = 100;
        do_cycle();
        p_mval = 0;
        for (int c = 0; c < 5; c++) do_cycle();
        chk("full_refill_fires", dut_fires, 1);
        drain();

        // Response back-pressure on port 0.
        hold_val[0] = 1'b1;
        hold_msg[0] = {3'd1, 8'h33, 32'h0000_0200, 2'd1, 32'h1234_5678};
        set_knobs(0, 100, 0, 100);
        for (int c = 0; c < 2; c++) do_cycle();
        #3;
        f0 = resp_fires;
        set_knobs(0, 100, 100, 0);
        for (int c = 0; c < 3; c++) do_cycle();
        #3;
        chk("bp_no_pop", resp_fires - f0, 0);
        p_rrdy = 100;
        do_cycle();
        #3;
        chk("bp_pop", resp_fires - f0, 1);
        drain();

        // Reset with three outstanding, then a stray response, then first grant.
        set_knobs(100, 100, 0, 100);
        for (int c = 0; c < 3; c++) do_cycle();
        chk("pre_rst_outstanding", tags_q.size(), 3);
        do_reset(1'b1);
        stray = 1'b1;
        set_knobs(0, 100, 100, 100);
        f0 = resp_fires;
        for (int c = 0; c < 3; c++) do_cycle();
        #3;
        chk("stray_not_accepted", resp_fires - f0, 0);
        stray = 1'b0;
        tag_opq = 1'b1;
        set_knobs(100, 100, 100, 100);
        do_cycle();
        tag_opq = 1'b0;
        chk("post_rst_grant", (grant_log.size() > 0) ? grant_log[0] : 8'hFF, 8'd0);
        drain();

        // Randomized traffic.
        for (int blk = 0; blk < 20; blk++) begin
            for (int i = 0; i < NREQS; i++) p_req[i] = $urandom_range(0, 100);
            p_mrdy = $urandom_range(10, 100);
            p_mval = $urandom_range(10, 100);
            p_rrdy = $urandom_range(10, 100);
            for (int c = 0; c < 100; c++) do_cycle();
        end
        drain();

`ifdef PAGERANK_MEM_ARB_STATS_EN
        do_reset(1'b0);
        set_knobs(0, 100, 100, 100);
        p_req[0] = 100;
        for (int c = 0; c < 70000; c++) do_cycle();
        drain();
        chk("stat_p0", grant_count[15:0], (cnt_model[0] > 65535) ? 16'hFFFF : 16'(cnt_model[0]));
        chk("stat_p1", grant_count[31:16], 16'(cnt_model[1]));
        chk("stat_p0_sat", grant_count[15:0], 16'hFFFF);
        chk("stat_p1_zero", grant_count[31:16], 16'h0000);
`endif

        chk("exp_q_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
